// File: rtl/dm_dma_master.sv
// dm_dma_master: bus initiator for the 8K x 16 data memory. Performs a block copy
// (memory-to-memory, 2 cycles per word) or a block fill (constant-to-memory,
// 1 cycle per word) on a single start pulse. All outputs are registered on posedge clk;
// the memory samples addr/re/we/wrt_data on the following negedge.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                1-cycle request, only honoured in IDLE
//   mode                 0 = copy, 1 = fill
//   src_addr, dst_addr   copy source / destination start addresses
//   len                  word count (values above 2^ADDR_W are clamped)
//   fill_data            fill constant
//   busy, done           transfer in progress / 1-cycle completion pulse
//   addr, re, we         memory address and strobes (never both high)
//   wrt_data, rd_data    memory write / read data
//   checksum             (only with DM_DMA_CHECKSUM_EN) mod-2^DATA_W sum of the words
//                        written by the current transfer, valid from the done cycle
//
// Optional feature macro: DM_DMA_CHECKSUM_EN.

module dm_dma_master #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  output logic              re,
  output logic              we,
  output logic [DATA_W-1:0] wrt_data,
`ifdef DM_DMA_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  input  logic [DATA_W-1:0] rd_data
);

  typedef enum logic [2:0] {StIdle, StRd, StWr, StFill, StDone} state_e;

  // Largest meaningful transfer: the whole memory.
  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(2 ** ADDR_W);

  state_e            state_q;
  logic [ADDR_W-1:0] src_ptr_q;
  logic [ADDR_W-1:0] dst_ptr_q;
  logic [LEN_W-1:0]  remain_q;
  logic [LEN_W-1:0]  len_clamped;

  always_comb begin
    len_clamped = (len > MaxLen) ? MaxLen : len;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      remain_q  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      addr      <= '0;
      re        <= 1'b0;
      we        <= 1'b0;
      wrt_data  <= '0;
`ifdef DM_DMA_CHECKSUM_EN
      checksum  <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            src_ptr_q <= src_addr;
            dst_ptr_q <= dst_addr;
            remain_q  <= len_clamped;
`ifdef DM_DMA_CHECKSUM_EN
            checksum  <= '0;
`endif
            if (len_clamped == '0) begin
              // Nothing to move: report completion without touching memory.
              state_q <= StDone;
              done    <= 1'b1;
            end else if (!mode) begin
              state_q <= StRd;
              busy    <= 1'b1;
              addr    <= src_addr;
              re      <= 1'b1;
            end else begin
              // The fill constant is captured once in wrt_data and held for the run.
              state_q  <= StFill;
              busy     <= 1'b1;
              addr     <= dst_addr;
              we       <= 1'b1;
              wrt_data <= fill_data;
            end
          end
        end
        StRd: begin
          // rd_data was returned on the negedge of this read cycle.
          state_q  <= StWr;
          re       <= 1'b0;
          we       <= 1'b1;
          addr     <= dst_ptr_q;
          wrt_data <= rd_data;
        end
        StWr: begin
          src_ptr_q <= src_ptr_q + 1'b1;
          dst_ptr_q <= dst_ptr_q + 1'b1;
          remain_q  <= remain_q - 1'b1;
          we        <= 1'b0;
`ifdef DM_DMA_CHECKSUM_EN
          checksum  <= checksum + wrt_data;
`endif
          if (remain_q == LEN_W'(1)) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state_q <= StRd;
            re      <= 1'b1;
            addr    <= src_ptr_q + 1'b1;
          end
        end
        StFill: begin
          dst_ptr_q <= dst_ptr_q + 1'b1;
          remain_q  <= remain_q - 1'b1;
`ifdef DM_DMA_CHECKSUM_EN
          checksum  <= checksum + wrt_data;
`endif
          if (remain_q == LEN_W'(1)) begin
            state_q <= StDone;
            we      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            addr <= dst_ptr_q + 1'b1;
          end
        end
        StDone: begin
          // A start seen here is deliberately dropped.
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_dma_master.sv
module tb_dm_dma_master;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [12:0] src_addr;
  logic [12:0] dst_addr;
  logic [13:0] len;
  logic [15:0] fill_data;
  logic        busy;
  logic        done;
  logic [12:0] addr;
  logic        re;
  logic        we;
  logic [15:0] wrt_data;
  logic [15:0] rd_data;
`ifdef DM_DMA_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  dm_dma_master #(
    .ADDR_W(13),
    .DATA_W(16),
    .LEN_W (14)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .fill_data(fill_data),
    .busy     (busy),
    .done     (done),
    .addr     (addr),
    .re       (re),
    .we       (we),
    .wrt_data (wrt_data),
`ifdef DM_DMA_CHECKSUM_EN
    .checksum (checksum),
`endif
    .rd_data  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: samples on negedge. Preload port used only while the DMA is idle.
  logic [15:0] mem [0:8191];
  logic        pl_en;
  logic [12:0] pl_addr;
  logic [15:0] pl_data;

  always @(negedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else begin
      if (re) rd_data <= mem[addr];
      if (we) mem[addr] <= wrt_data;
    end
  end

  // Bus monitor: cumulative activity counters and the ordered list of write addresses.
  int          wr_cnt, rd_cnt, busy_cyc, done_cnt, both_cnt;
  logic [12:0] wr_q[$];

  initial begin
    wr_cnt = 0; rd_cnt = 0; busy_cyc = 0; done_cnt = 0; both_cnt = 0;
  end

  always @(negedge clk) begin
    if (we) begin
      wr_cnt = wr_cnt + 1;
      wr_q.push_back(addr);
    end
    if (re) rd_cnt = rd_cnt + 1;
    if (busy) busy_cyc = busy_cyc + 1;
    if (done) done_cnt = done_cnt + 1;
    if (re && we) both_cnt = both_cnt + 1;
  end

  // Reference memory: what the specification says memory should hold.
  logic [15:0] ref_mem [0:8191];
  int total;
  int bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [12:0] a, input logic [15:0] dv);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = a; pl_data = dv;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[a] = dv;
  endtask

  task automatic do_xfer(input string tag, input logic m, input logic [12:0] s,
                         input logic [12:0] d, input logic [13:0] l, input logic [15:0] f,
                         input bit mid_start, input bit start_in_done);
    int          eff, lat, wr0, rd0, bz0, dn0, wq0, bad_addr, bad_data, exp_lat;
    logic [15:0] sum, v;
    logic [12:0] a;
    eff = (int'(l) > 8192) ? 8192 : int'(l);
    exp_lat = 1 + (m ? eff : 2 * eff);
    sum = '0;
    // Ascending word-by-word move: overlap with dst>src replicates naturally.
    for (int i = 0; i < eff; i++) begin
      a = 13'(int'(d) + i);
      v = m ? f : ref_mem[13'(int'(s) + i)];
      ref_mem[a] = v;
      sum = sum + v;
    end
    @(posedge clk); #1;
    wr0 = wr_cnt; rd0 = rd_cnt; bz0 = busy_cyc; dn0 = done_cnt; wq0 = wr_q.size();
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = l; fill_data = f;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble the request inputs to prove they were latched.
    src_addr = 13'($urandom); dst_addr = 13'($urandom); fill_data = 16'($urandom);
    len = 14'd3; mode = ~m;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (mid_start && lat == 2) start = 1'b1;
      if (mid_start && lat == 3) start = 1'b0;
    end while (!done && lat < 2 * eff + 20);
    if (done && start_in_done) start = 1'b1;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy low with done"}, {31'd0, busy}, 32'd0);
`ifdef DM_DMA_CHECKSUM_EN
    check({tag, " checksum"}, {16'd0, checksum}, {16'd0, sum});
`endif
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); #1;
    check({tag, " done one cycle"}, 32'(done_cnt - dn0), 32'd1);
    check({tag, " idle after"}, {30'd0, busy, done}, 32'd0);
    check({tag, " busy cycles"}, 32'(busy_cyc - bz0), 32'(m ? eff : 2 * eff));
    check({tag, " writes"}, 32'(wr_cnt - wr0), 32'(eff));
    check({tag, " reads"}, 32'(rd_cnt - rd0), 32'(m ? 0 : eff));
`ifdef DM_DMA_CHECKSUM_EN
    check({tag, " checksum held"}, {16'd0, checksum}, {16'd0, sum});
`endif
    bad_addr = 0;
    bad_data = 0;
    for (int i = 0; i < eff; i++) begin
      a = 13'(int'(d) + i);
      if (wq0 + i >= wr_q.size() || wr_q[wq0 + i] !== a) bad_addr++;
      if (mem[a] !== ref_mem[a]) bad_data++;
    end
    check({tag, " write addresses"}, 32'(bad_addr), 32'd0);
    check({tag, " memory contents"}, 32'(bad_data), 32'd0);
  endtask

  initial begin
    int          wr0;
    logic        rm;
    logic [12:0] rs, rd;
    logic [13:0] rl;
    total = 0; bad = 0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0; len = '0; fill_data = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset strobes", {30'd0, re, we}, 32'd0);
    check("reset addr", {19'd0, addr}, 32'd0);
    check("reset wrt_data", {16'd0, wrt_data}, 32'd0);
`ifdef DM_DMA_CHECKSUM_EN
    check("reset checksum", {16'd0, checksum}, 32'd0);
`endif
    rst_n = 1'b1;

    do_xfer("fill", 1'b1, 13'h0000, 13'h0100, 14'd4, 16'hA5A5, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) check("fill readback", {16'd0, mem[13'h0100 + 13'(i)]}, 32'hA5A5);

    poke(13'h0010, 16'h1111);
    poke(13'h0011, 16'h2222);
    poke(13'h0012, 16'h3333);
    do_xfer("copy", 1'b0, 13'h0010, 13'h0200, 14'd3, 16'h0000, 1'b0, 1'b0);
    check("copy word2", {16'd0, mem[13'h0202]}, 32'h3333);

    do_xfer("wrap", 1'b1, 13'h0000, 13'h1FFE, 14'd3, 16'h00FF, 1'b0, 1'b0);
    check("wrap word0", {16'd0, mem[13'h0000]}, 32'h00FF);

    do_xfer("zero len", 1'b0, 13'h0010, 13'h0300, 14'd0, 16'h0000, 1'b0, 1'b0);
    do_xfer("busy start", 1'b1, 13'h0000, 13'h0400, 14'd5, 16'h5A5A, 1'b1, 1'b0);

    // Reset during the read of the 3rd word of an 8-word copy.
    for (int i = 0; i < 8; i++) poke(13'h0500 + 13'(i), 16'(32'h1000 + i * 32'h0111));
    poke(13'h0602, 16'hDEAD);
    @(posedge clk); #1;
    wr0 = wr_cnt;
    start = 1'b1; mode = 1'b0; src_addr = 13'h0500; dst_addr = 13'h0600; len = 14'd8;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async reset strobes", {30'd0, re, we}, 32'd0);
    check("async reset busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk); #1;
    check("reset mid-op writes", 32'(wr_cnt - wr0), 32'd2);
    check("reset mid-op idle", {30'd0, busy, done}, 32'd0);
    check("reset mid-op word1", {16'd0, mem[13'h0601]}, {16'd0, ref_mem[13'h0501]});
    check("reset mid-op word3", {16'd0, mem[13'h0602]}, 32'hDEAD);
    ref_mem[13'h0600] = ref_mem[13'h0500];
    ref_mem[13'h0601] = ref_mem[13'h0501];
    do_xfer("post reset copy", 1'b0, 13'h0500, 13'h0700, 14'd2, 16'h0000, 1'b0, 1'b0);

    poke(13'h0020, 16'h8000);
    poke(13'h0021, 16'h8001);
    do_xfer("checksum copy", 1'b0, 13'h0020, 13'h0800, 14'd2, 16'h0000, 1'b0, 1'b0);
`ifdef DM_DMA_CHECKSUM_EN
    check("checksum value", {16'd0, checksum}, 32'h0001);
`endif

    do_xfer("overlap copy", 1'b0, 13'h0010, 13'h0011, 14'd4, 16'h0000, 1'b0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      rm = 1'($urandom_range(0, 1));
      rs = 13'($urandom);
      rd = 13'($urandom);
      rl = 14'($urandom_range(1, 12));
      if (!rm) begin
        for (int i = 0; i < int'(rl); i++) poke(13'(int'(rs) + i), 16'($urandom));
      end
      do_xfer("random", rm, rs, rd, rl, 16'($urandom), 1'b0, 1'b0);
    end

    do_xfer("clamp fill", 1'b1, 13'h0000, 13'h0123, 14'd9000, 16'hC3C3, 1'b0, 1'b0);
    check("never re and we", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
